controlador_estados_temp: RTL and testbench
===========================================

CONTROLADOR_ESTADOS_TEMP -- requirements
Module: controlador_estados_temp

Interface
REQ-001 Parameter CNT_W, default 16, shall set the width of the activity countdown and of the restante output.
REQ-002 Parameter T_DORMIR, default 1000, shall set the DORMINDO duration in clk cycles.
REQ-003 Parameter T_COMER, default 200, shall set the COMENDO duration in clk cycles.
REQ-004 Parameter T_AULA, default 500, shall set the DANDO_AULA duration in clk cycles.
REQ-005 Parameter JANELA, default 8, shall set the combo window in clk cycles for pairing b1/b2 presses.
REQ-006 clk  input  1  shall be the single clock; all logic is rising-edge.
REQ-007 rst_n  input  1  shall be the reset: synchronous, active-low.
REQ-008 b1  input  1  shall be the "eat" button, level, synchronous to clk.
REQ-009 b2  input  1  shall be the "sleep" button, level, synchronous to clk.
REQ-010 morreu  input  1  shall be the death request, level.
REQ-011 reviver  input  1  shall be the revive request, level.
REQ-012 estado  output  4  shall be the registered state: IDLE=0, DORMINDO=1, COMENDO=2, DANDO_AULA=3, MORTO=4.
REQ-013 restante  output  CNT_W  shall be the remaining activity cycles minus one; 0 outside activities.
REQ-014 fim  output  1  shall be a one-cycle pulse marking an activity ended by timeout.

Function
REQ-015 Button actions shall trigger only on a rising edge (current sample 1, previous sample 0); held levels shall cause no further action.
REQ-016 An internal state ESPERA shall exist; estado shall read IDLE while in ESPERA.
REQ-017 IDLE: rising edges on b1 and b2 in the same cycle shall go to DANDO_AULA; a single edge shall go to ESPERA, record the button, and load the window counter with JANELA-1.
REQ-018 ESPERA: an edge on the other button while the window counter is nonzero, or in the cycle it reaches 0, shall go to DANDO_AULA; otherwise, on expiry (counter 0, no other edge) it shall go to COMENDO (b1 recorded) or DORMINDO (b2 recorded); repeat edges of the recorded button shall be ignored.
REQ-019 Entering an activity shall load the countdown with T_x-1; it shall decrement every cycle, so the activity lasts exactly T_x cycles; restante shall equal the countdown.
REQ-020 Countdown at 0 in an activity shall go to IDLE next cycle with fim=1 in that same cycle only.
REQ-021 Early exit, without a fim pulse: DORMINDO on b2 edge; COMENDO on b1 edge; DANDO_AULA when b1 and b2 are both high and at least one has an edge.
REQ-022 Early exit and timeout in the same cycle shall resolve as timeout (fim=1).
REQ-023 morreu=1 shall take priority in every state, including ESPERA: next state MORTO, countdowns cleared, fim=0.
REQ-024 MORTO: reviver=1 with morreu=0 shall go to IDLE; otherwise stay; buttons ignored.
REQ-025 Legal parameters: 1 <= T_x <= 2^CNT_W, JANELA >= 1; other values are unsupported.

Reset
REQ-026 rst_n=0 at a clk edge shall force estado=IDLE, restante=0, fim=0, window counter=0, and both previous button samples=1, so that a button held through reset creates no edge.
REQ-027 Reset mid-activity or mid-ESPERA shall abort without a fim pulse; reset shall override morreu.

Structure
REQ-028 State encodings (including ESPERA=5) shall reside in package controlador_estados_pkg, shared with display logic.
REQ-029 Edge detection shall be a sub-module detector_borda (1-bit, sync active-low reset, previous sample resets to 1), instantiated once per button.

Verification
REQ-030 T_COMER=4, JANELA=3: b1 pulse at cycle 0 -> IDLE for 3 cycles, COMENDO 4 cycles with restante 3,2,1,0, then IDLE with fim=1 for one cycle.
REQ-031 b1 edge, then b2 edge 2 cycles later (JANELA=3) -> DANDO_AULA, restante=T_AULA-1.
REQ-032 DORMINDO at restante=5, b2 edge -> IDLE next cycle, fim=0; b2 held high for 10 cycles -> stays IDLE (then ESPERA once only, never re-triggered).
REQ-033 morreu=1 during ESPERA and during COMENDO -> MORTO next cycle, restante=0; morreu=1 with reviver=1 -> stays MORTO; morreu=0 with reviver=1 -> IDLE.
REQ-034 b1 held high while rst_n released -> no state change; rst_n=0 mid-DANDO_AULA -> IDLE, fim=0.

Source files
------------

// File: rtl/controlador_estados_pkg.sv
// Shared state encodings for the temp controller and any display logic that decodes estado.
package controlador_estados_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DORMINDO   = 3'd1,
    ST_COMENDO    = 3'd2,
    ST_DANDO_AULA = 3'd3,
    ST_MORTO      = 3'd4,
    ST_ESPERA     = 3'd5
  } estado_t;

  // ESPERA is an internal combo-window state; outside observers see it as IDLE.
  function automatic logic [ESTADO_W-1:0] estado_visivel(input estado_t st);
    if (st == ST_ESPERA) return ESTADO_W'(ST_IDLE);
    return ESTADO_W'(st);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// 1-bit rising-edge detector; the previous sample resets high so a level held through reset is not an edge.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic nivel,
  output logic borda
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= nivel;
  end

  assign borda = nivel & ~prev_q;

endmodule

// File: rtl/controlador_estados_temp.sv
// Activity controller: button presses (alone or paired within a window) start timed activities.
module controlador_estados_temp
  import controlador_estados_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int T_DORMIR = 1000,
  parameter int T_COMER  = 200,
  parameter int T_AULA   = 500,
  parameter int JANELA   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b1,
  input  logic             b2,
  input  logic             morreu,
  input  logic             reviver,
  output logic [3:0]       estado,
  output logic [CNT_W-1:0] restante,
  output logic             fim
);

  localparam int WIN_W = (JANELA > 1) ? $clog2(JANELA) : 1;

  localparam logic [CNT_W-1:0] L_DORMIR = CNT_W'(T_DORMIR - 1);
  localparam logic [CNT_W-1:0] L_COMER  = CNT_W'(T_COMER - 1);
  localparam logic [CNT_W-1:0] L_AULA   = CNT_W'(T_AULA - 1);
  localparam logic [WIN_W-1:0] L_JANELA = WIN_W'(JANELA - 1);

  logic e1, e2;

  detector_borda u_borda_b1 (.clk(clk), .rst_n(rst_n), .nivel(b1), .borda(e1));
  detector_borda u_borda_b2 (.clk(clk), .rst_n(rst_n), .nivel(b2), .borda(e2));

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             rec_b1_q, rec_b1_d;  // recorded button in ESPERA: 1 = b1, 0 = b2
  logic             fim_q, fim_d;
  logic             saida;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      rec_b1_q <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      rec_b1_q <= rec_b1_d;
      fim_q    <= fim_d;
    end
  end

  always_comb begin
    saida = 1'b0;
    unique case (state_q)
      ST_DORMINDO:   saida = e2;
      ST_COMENDO:    saida = e1;
      ST_DANDO_AULA: saida = b1 && b2 && (e1 || e2);
      default:       saida = 1'b0;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    rec_b1_d = rec_b1_q;
    fim_d    = 1'b0;

    if (morreu) begin
      state_d = ST_MORTO;
      cnt_d   = '0;
      win_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (e1 && e2) begin
            state_d = ST_DANDO_AULA;
            cnt_d   = L_AULA;
          end else if (e1 || e2) begin
            state_d  = ST_ESPERA;
            rec_b1_d = e1;
            win_d    = L_JANELA;
          end
        end
        ST_ESPERA: begin
          if (rec_b1_q ? e2 : e1) begin
            state_d = ST_DANDO_AULA;
            cnt_d   = L_AULA;
            win_d   = '0;
          end else if (win_q == '0) begin
            state_d = rec_b1_q ? ST_COMENDO : ST_DORMINDO;
            cnt_d   = rec_b1_q ? L_COMER : L_DORMIR;
          end else begin
            win_d = win_q - WIN_W'(1);
          end
        end
        ST_DORMINDO, ST_COMENDO, ST_DANDO_AULA: begin
          // Timeout wins over a simultaneous early exit.
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            fim_d   = 1'b1;
          end else if (saida) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_MORTO: begin
          if (reviver) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          win_d   = '0;
        end
      endcase
    end
  end

  assign estado   = estado_visivel(state_q);
  assign restante = cnt_q;
  assign fim      = fim_q;

endmodule

// File: tb/tb_controlador_estados_temp.sv
// Directed bench for controlador_estados_temp with short timings so every path is reachable quickly.
module tb_controlador_estados_temp;

  localparam int CNT_W    = 8;
  localparam int T_DORMIR = 20;
  localparam int T_COMER  = 4;
  localparam int T_AULA   = 6;
  localparam int JANELA   = 3;

  logic             clk = 1'b0;
  logic             rst_n, b1, b2, morreu, reviver;
  logic [3:0]       estado;
  logic [CNT_W-1:0] restante;
  logic             fim;

  int checks = 0;
  int errors = 0;

  controlador_estados_temp #(
    .CNT_W(CNT_W), .T_DORMIR(T_DORMIR), .T_COMER(T_COMER), .T_AULA(T_AULA), .JANELA(JANELA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .morreu(morreu), .reviver(reviver),
    .estado(estado), .restante(restante), .fim(fim)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] e_est,
                            input logic [CNT_W-1:0] e_rest, input logic e_fim);
    checks++;
    if ({estado, restante, fim} !== {e_est, e_rest, e_fim}) begin
      errors++;
      $display("FAIL %s: estado=%0d restante=%0d fim=%b, expected estado=%0d restante=%0d fim=%b",
               name, estado, restante, fim, e_est, e_rest, e_fim);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; b1 = 1'b1; b2 = 1'b0; morreu = 1'b1; reviver = 1'b0;
    tick(3);
    checks++;
    if ({estado, restante, fim} !== {4'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: estado=%0d restante=%0d fim=%b, expected 0/0/0", estado, restante, fim);
    end
    morreu = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < JANELA + 3; i++) begin
      tick();
      checks++;
      if (estado !== 4'd0) begin
        errors++;
        $display("FAIL reset_held_b1 cycle %0d: estado=%0d, expected 0", i, estado);
      end
    end
    b1 = 1'b0;
    tick();
  endtask

  task automatic test_comer;
    b1 = 1'b1;
    for (int i = 0; i < JANELA; i++) begin
      tick();
      b1 = 1'b0;
      checks++;
      if ({estado, restante, fim} !== {4'd0, 8'd0, 1'b0}) begin
        errors++;
        $display("FAIL comer_espera cycle %0d: estado=%0d restante=%0d fim=%b, expected 0/0/0",
                 i, estado, restante, fim);
      end
    end
    for (int k = 0; k < T_COMER; k++) begin
      tick();
      checks++;
      if ({estado, restante, fim} !== {4'd2, 8'(T_COMER - 1 - k), 1'b0}) begin
        errors++;
        $display("FAIL comer_countdown k=%0d: estado=%0d restante=%0d fim=%b, expected 2/%0d/0",
                 k, estado, restante, fim, T_COMER - 1 - k);
      end
    end
    tick();
    expect_out("comer_timeout_fim", 4'd0, 8'd0, 1'b1);
    tick();
    expect_out("comer_fim_one_cycle", 4'd0, 8'd0, 1'b0);
  endtask

  task automatic test_combo;
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    tick();
    b2 = 1'b1;
    tick();
    expect_out("combo_b1_then_b2", 4'd3, 8'(T_AULA - 1), 1'b0);
    b2 = 1'b0;
    tick();
    expect_out("combo_aula_decrement", 4'd3, 8'(T_AULA - 2), 1'b0);
    b1 = 1'b1; b2 = 1'b1;
    tick();
    expect_out("aula_early_exit", 4'd0, 8'd0, 1'b0);
    b1 = 1'b0; b2 = 1'b0;
    tick();
    b1 = 1'b1; b2 = 1'b1;
    tick();
    expect_out("idle_simultaneous_edges", 4'd3, 8'(T_AULA - 1), 1'b0);
    tick();
    expect_out("aula_held_no_exit", 4'd3, 8'(T_AULA - 2), 1'b0);
    b1 = 1'b0; b2 = 1'b0;
    tick(T_AULA - 2);
    expect_out("aula_last_cycle", 4'd3, 8'd0, 1'b0);
    tick();
    expect_out("aula_timeout_fim", 4'd0, 8'd0, 1'b1);
    tick();
  endtask

  task automatic test_dormir;
    b2 = 1'b1;
    tick();
    b2 = 1'b0;
    tick(JANELA);
    expect_out("dormir_entry", 4'd1, 8'(T_DORMIR - 1), 1'b0);
    tick(T_DORMIR - 1 - 5);
    expect_out("dormir_restante_5", 4'd1, 8'd5, 1'b0);
    b2 = 1'b1;
    tick();
    expect_out("dormir_early_exit", 4'd0, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (estado !== 4'd0) begin
        errors++;
        $display("FAIL dormir_held_b2 cycle %0d: estado=%0d, expected 0", i, estado);
      end
    end
    b2 = 1'b0;
    tick(JANELA + 2);
    expect_out("dormir_no_retrigger", 4'd0, 8'd0, 1'b0);
    // Second press with a repeat edge of b2 inside the window, which must be ignored.
    b2 = 1'b1;
    tick();
    b2 = 1'b0;
    tick();
    b2 = 1'b1;
    tick();
    b2 = 1'b0;
    tick();
    expect_out("espera_repeat_ignored", 4'd1, 8'(T_DORMIR - 1), 1'b0);
    tick(T_DORMIR - 1);
    expect_out("dormir_last_cycle", 4'd1, 8'd0, 1'b0);
    b2 = 1'b1;
    tick();
    expect_out("timeout_beats_exit", 4'd0, 8'd0, 1'b1);
    b2 = 1'b0;
    tick();
  endtask

  task automatic test_morte;
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    morreu = 1'b1;
    tick();
    expect_out("morreu_in_espera", 4'd4, 8'd0, 1'b0);
    reviver = 1'b1;
    tick();
    expect_out("morreu_and_reviver", 4'd4, 8'd0, 1'b0);
    morreu = 1'b0;
    tick();
    expect_out("reviver_to_idle", 4'd0, 8'd0, 1'b0);
    reviver = 1'b0;
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    tick(JANELA + 1);
    expect_out("comer_before_death", 4'd2, 8'(T_COMER - 2), 1'b0);
    morreu = 1'b1;
    tick();
    expect_out("morreu_in_comer", 4'd4, 8'd0, 1'b0);
    morreu = 1'b0;
    b1 = 1'b1; b2 = 1'b1;
    tick();
    expect_out("morto_ignores_buttons", 4'd4, 8'd0, 1'b0);
    reviver = 1'b1;
    tick();
    reviver = 1'b0;
    tick(JANELA + 1);
    expect_out("revived_held_buttons", 4'd0, 8'd0, 1'b0);
    b1 = 1'b0; b2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_aula;
    b1 = 1'b1; b2 = 1'b1;
    tick();
    expect_out("aula_before_reset", 4'd3, 8'(T_AULA - 1), 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    expect_out("reset_mid_aula", 4'd0, 8'd0, 1'b0);
    b1 = 1'b0; b2 = 1'b0;
    rst_n = 1'b1;
    tick(T_AULA + 2);
    expect_out("after_reset_idle", 4'd0, 8'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_comer();
    test_combo();
    test_dormir();
    test_morte();
    test_reset_aula();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
